// File: rtl/latch_reader_pkg.sv
// Shared types and defaults for the latch read side: FSM state encoding and default word width.
// The enum values are fixed so the state register is readable in waveforms and netlists.
package latch_reader_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchronizer: a chain of STAGES flops that brings an asynchronous level into clk.
// Every stage resets to 0, so a level that is high at reset release appears as a rising edge.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        chain_reg[gi] <= 1'b0;
                    end else begin
                        chain_reg[gi] <= d;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        chain_reg[gi] <= 1'b0;
                    end else begin
                        chain_reg[gi] <= chain_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/latch_reader.sv
// Clocked read side of a D-latch bank: waits for the latch to close and its word to settle,
// then captures that word once and offers it downstream on a valid/ready handshake.
module latch_reader
    import latch_reader_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic [WIDTH-1:0] Q_in,
    input  logic             ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int                CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic             en_s;
    logic             en_prev_reg;
    logic [WIDTH-1:0] q_prev_reg;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             overrun_reg;

    logic close_evt;
    logic open_lvl;
    logic stable;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_en_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (En),
        .q    (en_s)
    );

    // Multi-bit Q_in is never synchronized per bit; it is only trusted after it has
    // compared equal to its own previous sample for SETTLE_CYCLES consecutive cycles.
    assign close_evt = en_prev_reg & ~en_s;
    assign open_lvl  = en_s;
    assign stable    = (Q_in == q_prev_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev_reg <= 1'b0;
            q_prev_reg  <= '0;
        end else begin
            en_prev_reg <= en_s;
            q_prev_reg  <= Q_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            // A same-cycle overrun set below overrides this clear.
            if (ovr_clr) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (close_evt) begin
                        state_reg <= ST_SETTLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (open_lvl) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (!stable) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        data_reg  <= Q_in;
                        valid_reg <= 1'b1;
                        state_reg <= ST_HOLD;
                        cnt_reg   <= '0;
                    end else if (cnt_reg < CNT_LAST) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (valid_reg && ready) begin
                        valid_reg <= 1'b0;
                        cnt_reg   <= '0;
                        if (close_evt) begin
                            state_reg <= ST_SETTLE;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else if (close_evt) begin
                        // Latch closed on a new word we have no room for; keep the old one.
                        overrun_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_reg;
    assign valid    = valid_reg;
    assign busy     = busy_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_latch_reader.sv
// Self-checking bench for latch_reader: directed scenarios plus randomized words checked
// against a window-based model of when a settled word must appear.
module tb_latch_reader;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int S    = 2;
    localparam int LEN  = 24;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         En      = 1'b1;
    logic [W-1:0] Q_in    = 8'hA5;
    logic         ready   = 1'b0;
    logic         ovr_clr = 1'b0;
    logic [W-1:0] data_out;
    logic         valid;
    logic         busy;
    logic         overrun;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_data = '0;

    latch_reader #(
        .WIDTH        (W),
        .SYNC_STAGES  (SYNC),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .En      (En),
        .Q_in    (Q_in),
        .ready   (ready),
        .ovr_clr (ovr_clr),
        .data_out(data_out),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic open_latch();
        En = 1'b1;
        repeat (SYNC + 2) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        En    = 1'b1;
        Q_in  = 8'hA5;
        repeat (3) step();
        n_vec++;
        if (valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values: got v=%b b=%b o=%b d=%h, want 0 0 0 00",
                     valid, busy, overrun, data_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release_en_high: cycle %0d got v=%b b=%b, want 0 0",
                         i, valid, busy);
            end
        end
        $display("txn reset_release En=1 Q_in=a5");
    endtask

    // Model: En_s falls at edge SYNC, the first settle comparison is at edge SYNC+2, and the
    // word is taken at the first edge t closing S consecutive equal-sample comparisons.
    task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int chg, input int d, input string tag);
        logic [W-1:0] hist [0:LEN];
        int           t;
        bit           ok;
        for (int s = 0; s <= LEN; s++) hist[s] = (s >= chg) ? b : a;
        t = -1;
        for (int s = SYNC + 1 + S; s <= LEN && t < 0; s++) begin
            ok = 1'b1;
            for (int j = s - S; j < s; j++) if (hist[j] !== hist[s]) ok = 1'b0;
            if (ok) t = s;
        end
        if (t < 0 || t + d + 2 > LEN) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_model: no capture edge within %0d cycles", tag, LEN);
            return;
        end
        ready = 1'b0;
        Q_in  = hist[0];
        open_latch();
        En = 1'b0;
        for (int s = 1; s <= t + d + 2; s++) begin
            Q_in  = hist[s];
            ready = (s >= t + 1 + d);
            step();
            n_vec++;
            if (valid !== (s >= t && s <= t + d)) begin
                n_err++;
                $display("FAIL %s_valid: edge %0d got %b, want %b", tag, s, valid,
                         (s >= t && s <= t + d));
            end
            n_vec++;
            if (busy !== (s >= SYNC + 1 && s <= t + d)) begin
                n_err++;
                $display("FAIL %s_busy: edge %0d got %b, want %b", tag, s, busy,
                         (s >= SYNC + 1 && s <= t + d));
            end
            if (s >= t && s <= t + d) begin
                n_vec++;
                if (data_out !== hist[t]) begin
                    n_err++;
                    $display("FAIL %s_data: edge %0d got %h, want %h", tag, s, data_out, hist[t]);
                end
            end
        end
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL %s_overrun: got %b, want 0", tag, overrun);
        end
        ready     = 1'b0;
        En        = 1'b1;
        last_data = hist[t];
        $display("txn %s a=%h b=%h chg=%0d rdy_delay=%0d capture_edge=%0d", tag, a, b, chg, d, t);
    endtask

    task automatic test_basic();
        run_word(8'h3C, 8'h3C, 99, 0, "basic");
    endtask

    task automatic test_settle_restart();
        run_word(8'h11, 8'h22, 4, 0, "settle_restart");
    endtask

    task automatic test_abort();
        Q_in = 8'h99;
        open_latch();
        En = 1'b0;
        step();
        En = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (valid !== 1'b0) begin
                n_err++;
                $display("FAIL abort_valid: cycle %0d got %b, want 0", i, valid);
            end
        end
        n_vec++;
        if (data_out !== last_data || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_data: got d=%h b=%b, want d=%h b=0", data_out, busy, last_data);
        end
        $display("txn abort Q_in=99");
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        Q_in  = 8'h55;
        open_latch();
        En = 1'b0;
        repeat (SYNC + 1 + S) step();
        n_vec++;
        if (valid !== 1'b1 || data_out !== 8'h55) begin
            n_err++;
            $display("FAIL overrun_first: got v=%b d=%h, want 1 55", valid, data_out);
        end
        open_latch();
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_early: got %b, want 0", overrun);
        end
        Q_in = 8'h66;
        En   = 1'b0;
        repeat (SYNC + 2) step();
        n_vec++;
        if (overrun !== 1'b1 || data_out !== 8'h55 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_set: got o=%b d=%h v=%b, want 1 55 1", overrun, data_out, valid);
        end
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_drain: got v=%b, want 0", valid);
        end
        last_data = 8'h55;
        En = 1'b1;
        $display("txn overrun first=55 second=66");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x;
        logic [W-1:0] y;
        x = W'($urandom);
        y = ~x;
        ready = 1'b0;
        Q_in  = x;
        open_latch();
        En = 1'b0;
        repeat (SYNC + 1 + S) step();
        n_vec++;
        if (valid !== 1'b1 || data_out !== x) begin
            n_err++;
            $display("FAIL b2b_first: got v=%b d=%h, want 1 %h", valid, data_out, x);
        end
        open_latch();
        Q_in = y;
        En   = 1'b0;
        step();
        step();
        ready = 1'b1;
        step();
        n_vec++;
        if (valid !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_handshake: got v=%b b=%b o=%b, want 0 1 0", valid, busy, overrun);
        end
        step();
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_settle: got v=%b, want 0", valid);
        end
        step();
        n_vec++;
        if (valid !== 1'b1 || data_out !== y || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b d=%h o=%b, want 1 %h 0", valid, data_out, overrun, y);
        end
        step();
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got v=%b, want 0", valid);
        end
        ready     = 1'b0;
        En        = 1'b1;
        last_data = y;
        $display("txn back_to_back first=%h second=%h", x, y);
    endtask

    task automatic test_reset_hold();
        logic [W-1:0] z;
        z = W'($urandom) | 8'h01;
        ready = 1'b0;
        Q_in  = z;
        open_latch();
        En = 1'b0;
        repeat (SYNC + 1 + S) step();
        n_vec++;
        if (valid !== 1'b1 || data_out !== z) begin
            n_err++;
            $display("FAIL rst_hold_capture: got v=%b d=%h, want 1 %h", valid, data_out, z);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (valid !== 1'b0 || data_out !== 8'h00 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_hold_async: got v=%b d=%h b=%b, want 0 00 0", valid, data_out, busy);
        end
        step();
        rst_n     = 1'b1;
        En        = 1'b1;
        last_data = '0;
        $display("txn reset_mid_hold word=%h", z);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_word(W'($urandom), W'($urandom), int'($urandom_range(1, 7)),
                     int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_settle_restart();
        test_abort();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
